// File: rtl/exec_seq_if.sv
// Request/response channel between the execute sequencer and its client.
interface exec_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_icode;
    logic [3:0]       in_ifun;
    logic [WIDTH-1:0] in_valA;
    logic [WIDTH-1:0] in_valB;
    logic [WIDTH-1:0] in_valC;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_valE;
    logic             out_cnd;
    logic             out_err;

    // Client side: issues requests, consumes responses.
    modport master (
        output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, out_ready,
        input  in_ready, out_valid, out_valE, out_cnd, out_err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, out_ready,
        output in_ready, out_valid, out_valE, out_cnd, out_err
    );
endinterface

// File: rtl/exec_sequencer.sv
// SEQ execute-stage controller: accepts one decoded instruction, drives the
// shared ALU for ALU_WAIT cycles, updates ZF/SF/OF for OPq and returns
// valE/cnd/err over a valid/ready response.
module exec_sequencer #(
    parameter int         WIDTH    = 64,
    parameter int         ALU_WAIT = 1,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    exec_seq_if.slave        bus,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             busy
);
    localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [CW-1:0] WLAST = CW'(ALU_WAIT - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [3:0]       icode_q, icode_d;
    logic [3:0]       ifun_q, ifun_d;
    logic             ierr_q, ierr_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] valE_q, valE_d;
    logic             cnd_q, cnd_d;
    logic             err_q, err_d;
    logic [2:0]       cc_q, cc_d;     // {ZF,SF,OF}

    logic             req_err;
    logic [1:0]       tbl_op;
    logic [WIDTH-1:0] tbl_a, tbl_b;

    // Y86 condition evaluation against a {ZF,SF,OF} snapshot.
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        {zf, sf, of} = cc;
        case (fn)
            4'd1:    return (sf ^ of) | zf;
            4'd2:    return sf ^ of;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !(sf ^ of);
            4'd6:    return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Legality check and ALU operand selection for the incoming request.
    always_comb begin
        req_err = 1'b0;
        tbl_op  = OP_ADD;
        tbl_a   = '0;
        tbl_b   = '0;
        case (bus.in_icode)
            4'h2: begin tbl_a = bus.in_valA; req_err = bus.in_ifun > 4'd6; end
            4'h3: tbl_a = bus.in_valC;
            4'h4, 4'h5: begin tbl_a = bus.in_valC; tbl_b = bus.in_valB; end
            4'h6: begin
                tbl_op  = bus.in_ifun[1:0];
                tbl_a   = bus.in_valB;
                tbl_b   = bus.in_valA;
                req_err = bus.in_ifun > 4'd3;
            end
            4'h7: req_err = bus.in_ifun > 4'd6;
            4'h8, 4'hA: begin tbl_op = OP_SUB; tbl_a = bus.in_valB; tbl_b = WIDTH'(8); end
            4'h9, 4'hB: begin tbl_a = bus.in_valB; tbl_b = WIDTH'(8); end
            4'h0, 4'h1: ;
            default: req_err = 1'b1;
        endcase
        // Illegal requests leave the ALU idle.
        if (req_err) begin
            tbl_op = OP_ADD;
            tbl_a  = '0;
            tbl_b  = '0;
        end
    end

    // Next-state and datapath updates for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ierr_d  = ierr_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        valE_d  = valE_q;
        cnd_d   = cnd_q;
        err_d   = err_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = ISSUE;
                wcnt_d  = '0;
                icode_d = bus.in_icode;
                ifun_d  = bus.in_ifun;
                ierr_d  = req_err;
                op_d    = tbl_op;
                a_d     = tbl_a;
                b_d     = tbl_b;
            end
            ISSUE: if (wcnt_q == WLAST) begin
                state_d = RESP;
                err_d   = ierr_q;
                valE_d  = ierr_q ? '0 : alu_out;
                // cnd sees the flags as they stood before this op.
                if (ierr_q)
                    cnd_d = 1'b0;
                else if (icode_q == 4'h2 || icode_q == 4'h7)
                    cnd_d = cond_eval(ifun_q, cc_q);
                else
                    cnd_d = (icode_q != 4'h6);
                if (icode_q == 4'h6 && !ierr_q)
                    cc_d = {alu_out == '0, alu_out[WIDTH-1], alu_ovf && !op_q[1]};
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
            RESP: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            icode_q <= '0;
            ifun_q  <= '0;
            ierr_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valE_q  <= '0;
            cnd_q   <= 1'b0;
            err_q   <= 1'b0;
            cc_q    <= CC_RESET;
        end else begin
            wcnt_q  <= wcnt_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ierr_q  <= ierr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valE_q  <= valE_d;
            cnd_q   <= cnd_d;
            err_q   <= err_d;
            cc_q    <= cc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == RESP);
    assign bus.out_valE  = valE_q;
    assign bus.out_cnd   = cnd_q;
    assign bus.out_err   = err_q;
    assign busy          = (state_q != IDLE);
    assign alu_op        = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign {cc_zf, cc_sf, cc_of} = cc_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench: DUT0 with ALU_WAIT=1, DUT1 with ALU_WAIT=3, each with a
// behavioural ALU.
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic sel = 1'b0;

    logic [3:0]  t_icode = '0, t_ifun = '0;
    logic [63:0] t_valA = '0, t_valB = '0, t_valC = '0;
    logic        v0 = 1'b0, v1 = 1'b0, t_ordy = 1'b0;

    exec_seq_if #(.WIDTH(64)) if0 ();
    exec_seq_if #(.WIDTH(64)) if1 ();

    logic [1:0]  op0, op1;
    logic [63:0] a0, b0, a1, b1, r0, r1;
    logic        ovf0, ovf1;
    logic        zf0, sf0, of0, zf1, sf1, of1, busy0, busy1;

    assign if0.in_valid = v0;       assign if1.in_valid = v1;
    assign if0.in_icode = t_icode;  assign if1.in_icode = t_icode;
    assign if0.in_ifun  = t_ifun;   assign if1.in_ifun  = t_ifun;
    assign if0.in_valA  = t_valA;   assign if1.in_valA  = t_valA;
    assign if0.in_valB  = t_valB;   assign if1.in_valB  = t_valB;
    assign if0.in_valC  = t_valC;   assign if1.in_valC  = t_valC;
    assign if0.out_ready = t_ordy;  assign if1.out_ready = t_ordy;

    // Overflow is not meaningful for logic ops; drive it high there so the
    // sequencer's masking of OF is exercised.
    function automatic logic [64:0] alu_f(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        v;
        case (op)
            2'b00:   begin r = a + b; v = (a[63] == b[63]) && (r[63] != a[63]); end
            2'b01:   begin r = a - b; v = (a[63] != b[63]) && (r[63] != a[63]); end
            2'b10:   begin r = a & b; v = 1'b1; end
            default: begin r = a ^ b; v = 1'b1; end
        endcase
        return {v, r};
    endfunction

    assign {ovf0, r0} = alu_f(op0, a0, b0);
    assign {ovf1, r1} = alu_f(op1, a1, b1);

    exec_sequencer #(.WIDTH(64), .ALU_WAIT(1), .CC_RESET(3'b100)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave),
        .alu_op(op0), .alu_a(a0), .alu_b(b0), .alu_out(r0), .alu_ovf(ovf0),
        .cc_zf(zf0), .cc_sf(sf0), .cc_of(of0), .busy(busy0));

    exec_sequencer #(.WIDTH(64), .ALU_WAIT(3), .CC_RESET(3'b100)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave),
        .alu_op(op1), .alu_a(a1), .alu_b(b1), .alu_out(r1), .alu_ovf(ovf1),
        .cc_zf(zf1), .cc_sf(sf1), .cc_of(of1), .busy(busy1));

    // Observed signals of whichever DUT is under test.
    logic        m_ov, m_ir, m_busy, m_cnd, m_err;
    logic [63:0] m_valE;
    logic [2:0]  m_cc;
    assign m_ov   = sel ? if1.out_valid : if0.out_valid;
    assign m_ir   = sel ? if1.in_ready  : if0.in_ready;
    assign m_busy = sel ? busy1 : busy0;
    assign m_cnd  = sel ? if1.out_cnd : if0.out_cnd;
    assign m_err  = sel ? if1.out_err : if0.out_err;
    assign m_valE = sel ? if1.out_valE : if0.out_valE;
    assign m_cc   = sel ? {zf1, sf1, of1} : {zf0, sf0, of0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Present one request, wait for the response and check it (response left pending).
    task automatic issue(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [63:0] e_valE, input logic e_cnd, input logic e_err,
                         input logic [2:0] e_cc);
        int lat;
        t_icode = ic; t_ifun = fn; t_valA = va; t_valB = vb; t_valC = vc;
        chk({tag, ".rdy"}, 64'(m_ir), 64'd1);
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        lat = 1;
        while (!m_ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), sel ? 64'd4 : 64'd2);
        chk({tag, ".valE"}, m_valE, e_valE);
        chk({tag, ".cnd"}, 64'(m_cnd), 64'(e_cnd));
        chk({tag, ".err"}, 64'(m_err), 64'(e_err));
        chk({tag, ".cc"}, 64'(m_cc), 64'(e_cc));
    endtask

    task automatic pop(input string tag);
        t_ordy = 1'b1;
        @(posedge clk); #1;
        t_ordy = 1'b0;
        chk({tag, ".drop"}, 64'(m_ov), 64'd0);
        chk({tag, ".idle"}, 64'(m_ir), 64'd1);
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        chk("rst.rdy",  64'(m_ir), 64'd1);
        chk("rst.ov",   64'(m_ov), 64'd0);
        chk("rst.cc",   64'(m_cc), 64'b100);
        chk("rst.busy", 64'(m_busy), 64'd0);
        chk("rst.alua", a0, 64'd0);
        chk("rst.valE", m_valE, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post.rdy", 64'(m_ir), 64'd1);

        // ALU_WAIT=1 directed vectors
        issue("addovf", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
              64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011);
        pop("addovf");
        issue("cmovl", 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 64'h55, 1'b0, 1'b0, 3'b011);
        pop("cmovl");
        issue("cmovne", 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 64'h55, 1'b1, 1'b0, 3'b011);
        pop("cmovne");
        issue("sub", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100);
        pop("sub");
        issue("je", 4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 64'd0, 1'b1, 1'b0, 3'b100);
        pop("je");
        issue("jne", 4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 64'd0, 1'b0, 1'b0, 3'b100);
        pop("jne");
        issue("push", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b1, 1'b0, 3'b100);
        pop("push");
        issue("pop", 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 64'h108, 1'b1, 1'b0, 3'b100);
        pop("pop");
        issue("xor", 4'h6, 4'h3, 64'hFF00, 64'hF0F0, 64'd0, 64'h0FF0, 1'b0, 1'b0, 3'b000);
        pop("xor");
        issue("mrmov", 4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 64'h30, 1'b1, 1'b0, 3'b000);
        pop("mrmov");
        issue("irmov", 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 64'h1234, 1'b1, 1'b0, 3'b000);
        pop("irmov");
        issue("badic", 4'hC, 4'h0, 64'd3, 64'd4, 64'd5, 64'd0, 1'b0, 1'b1, 3'b000);
        pop("badic");
        issue("badj", 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b000);
        pop("badj");
        issue("badop", 4'h6, 4'h4, 64'd1, 64'd1, 64'd0, 64'd0, 1'b0, 1'b1, 3'b000);
        pop("badop");

        // Backpressure: response must hold while a new request is ignored.
        issue("and", 4'h6, 4'h2, 64'h0F, 64'hFF, 64'd0, 64'h0F, 1'b0, 1'b0, 3'b000);
        t_icode = 4'h6; t_ifun = 4'h0; t_valA = 64'd1; t_valB = 64'd1;
        v0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.valE", m_valE, 64'h0F);
            chk("bp.cnd",  64'(m_cnd), 64'd0);
            chk("bp.ov",   64'(m_ov), 64'd1);
            chk("bp.rdy",  64'(m_ir), 64'd0);
        end
        v0 = 1'b0;
        pop("bp");
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= m_ov;
        end
        chk("bp.noresp", 64'(seen), 64'd0);
        chk("bp.hold",   m_valE, 64'h0F);

        // ALU_WAIT=3 instance
        sel = 1'b1;
        issue("w3add", 4'h6, 4'h0, 64'd3, 64'd2, 64'd0, 64'd5, 1'b0, 1'b0, 3'b000);
        pop("w3add");
        issue("w3bad", 4'hD, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b000);
        pop("w3bad");

        // Reset in the middle of ISSUE drops the op and restores CC.
        t_icode = 4'h6; t_ifun = 4'h0; t_valA = 64'd1; t_valB = 64'h7FFF_FFFF_FFFF_FFFF;
        v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("mid.busy", 64'(m_busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid.busy0", 64'(m_busy), 64'd0);
        chk("mid.ov",    64'(m_ov), 64'd0);
        chk("mid.rdy",   64'(m_ir), 64'd1);
        chk("mid.cc",    64'(m_cc), 64'b100);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= m_ov;
        end
        chk("mid.noresp", 64'(seen), 64'd0);
        chk("mid.cc2",    64'(m_cc), 64'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
